// File: rtl/argmax_sequencer.sv
// rtl/argmax_sequencer.sv - streaming signed argmax/argmin over a multi-beat vector
module argmax_sequencer #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 13,
    parameter int BEATS      = 4,
    localparam int IDX_W     = $clog2(N * BEATS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    s,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH*N-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [IDX_W-1:0]        out_index,
    output logic                    busy
);

    localparam int LANE_W = $clog2(N);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [BEAT_W-1:0]             beat_cnt;
    logic                          mode;
    logic signed [DATA_WIDTH-1:0]  best_val;
    logic [IDX_W-1:0]              best_idx;
    logic signed [DATA_WIDTH-1:0]  lane_val;
    logic signed [DATA_WIDTH-1:0]  beat_val;
    logic [LANE_W-1:0]             beat_lane;
    logic [IDX_W-1:0]              beat_idx;
    logic                          better;
    logic                          accept;
    logic                          last_beat;

    // Reduce the current beat to its winner; strict compare keeps the lowest lane on ties.
    always_comb begin
        lane_val  = '0;
        beat_val  = in_data[DATA_WIDTH*N-1 -: DATA_WIDTH];
        beat_lane = '0;
        for (int i = 1; i < N; i++) begin
            lane_val = in_data[DATA_WIDTH*(N-1-i) +: DATA_WIDTH];
            if (mode ? (lane_val > beat_val) : (lane_val < beat_val)) begin
                beat_val  = lane_val;
                beat_lane = LANE_W'(i);
            end
        end
        beat_idx = IDX_W'(int'(beat_cnt) * N + int'(beat_lane));
        better   = mode ? (beat_val > best_val) : (beat_val < best_val);
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                accept   = in_valid;
                if (in_valid && last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset aborts any vector in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Mode latch, beat counter and running winner; first beat loads unconditionally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode     <= 1'b0;
            beat_cnt <= '0;
            best_val <= '0;
            best_idx <= '0;
        end else begin
            if (state == IDLE && start) begin
                mode     <= s;
                beat_cnt <= '0;
            end
            if (accept) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                if (beat_cnt == '0 || better) begin
                    best_val <= beat_val;
                    best_idx <= beat_idx;
                end
            end
        end
    end

    assign out_data  = best_val;
    assign out_index = best_idx;

endmodule

// File: tb/tb_argmax_sequencer.sv
// tb/tb_argmax_sequencer.sv - directed self-checking bench for argmax_sequencer
module tb_argmax_sequencer;

    localparam int N     = 4;
    localparam int DW    = 13;
    localparam int BEATS = 2;
    localparam int IDX_W = $clog2(N * BEATS);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              s;
    logic              in_valid;
    logic              in_ready;
    logic [DW*N-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [IDX_W-1:0]  out_index;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    argmax_sequencer #(.N(N), .DATA_WIDTH(DW), .BEATS(BEATS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s         (s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] d13(input int v);
        logic [31:0] t;
        t = v;
        return t[DW-1:0];
    endfunction

    function automatic logic [DW*N-1:0] pack(input int a, input int b, input int c, input int d);
        return {d13(a), d13(b), d13(c), d13(d)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input int val, input int idx);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_data"},  32'(out_data), 32'(d13(val)));
        chk({tag, "_index"}, 32'(out_index), 32'(idx));
    endtask

    // Two back-to-back beats, result checked one cycle after the last beat, then drained.
    task automatic run_vec(input string tag, input logic mode,
                           input logic [DW*N-1:0] b0, input logic [DW*N-1:0] b1,
                           input int val, input int idx);
        start = 1'b1;
        s     = mode;
        tick();
        start = 1'b0;
        chk({tag, "_accum_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_accum_busy"},  32'(busy), 32'd1);
        in_valid = 1'b1;
        in_data  = b0;
        tick();
        chk({tag, "_mid_nvalid"}, 32'(out_valid), 32'd0);
        in_data = b1;
        tick();
        in_valid = 1'b0;
        check_result(tag, val, idx);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_busy"},  32'(busy), 32'd0);
        chk({tag, "_hold_data"},  32'(out_data), 32'(d13(val)));
        chk({tag, "_hold_index"}, 32'(out_index), 32'(idx));
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        s         = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready",  32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_out_data",  32'(out_data), 32'd0);
        chk("rst_out_index", 32'(out_index), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        run_vec("max", 1'b1, pack(3, -7, 9, 1), pack(4, 12, -2, 0), 12, 5);
        run_vec("min", 1'b0, pack(3, -7, 9, 1), pack(4, 12, -8, 0), -8, 6);
        run_vec("tie_max", 1'b1, pack(5, 5, 1, 1), pack(5, 0, 0, 0), 5, 0);
        run_vec("tie_min", 1'b0, pack(2, 2, 2, 2), pack(2, 2, 2, 2), 2, 0);
        run_vec("min_late", 1'b0, pack(0, 1, 2, 3), pack(5, -1, -1, 7), -1, 5);

        // Stall between beats and backpressure on the result; start and s wiggled while busy.
        start = 1'b1;
        s     = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = pack(3, -7, 9, 1);
        tick();
        in_valid = 1'b0;
        in_data  = pack(100, 100, 100, 100);
        s        = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            tick();
            chk("stall_ready", 32'(in_ready), 32'd1);
            chk("stall_valid", 32'(out_valid), 32'd0);
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = pack(4, 12, -2, 0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start = (i == 2);
            check_result("bp", 12, 5);
            tick();
        end
        start = 1'b0;
        check_result("bp_last", 12, 5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle_busy", 32'(busy), 32'd0);
        tick();
        chk("bp_no_restart", 32'(busy), 32'd0);

        // Asynchronous reset after the first beat, checked before any clock edge.
        start = 1'b1;
        s     = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = pack(9, 9, 9, 9);
        tick();
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_in_ready",  32'(in_ready), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy",      32'(busy), 32'd0);
        chk("arst_out_data",  32'(out_data), 32'd0);
        chk("arst_out_index", 32'(out_index), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_vec("post_rst", 1'b1, pack(1, 2, 3, 4), pack(0, 0, 0, 0), 4, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
